ieeedrv_seek: RTL and testbench

IEEEDRV_SEEK -- requirements
Module: ieeedrv_seek

---
 rtl/ieeedrv_seek_if.sv | 24 ++
 rtl/ieeedrv_seek.sv | 166 ++++++++++++++++
 tb/tb_ieeedrv_seek.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ieeedrv_seek_if.sv
// Command/status bundle between a drive controller and the head seek engine.
// The master issues seek requests; the slave reports the head position.
interface ieeedrv_seek_if;
  logic       drv_type;
  logic       home;
  logic       seek_req;
  logic [7:0] target;
  logic [1:0] stp;
  logic       hd;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] cur_track;

  modport master (
    output drv_type, home, seek_req, target,
    input  stp, hd, busy, done, error, cur_track
  );

  modport slave (
    input  drv_type, home, seek_req, target,
    output stp, hd, busy, done, error, cur_track
  );
endinterface

// File: rtl/ieeedrv_seek.sv
// Head seek engine for 4040/8250 drives: walks the stepper phase toward a
// requested track, one phase per step interval, then waits for head settle.
//
// state  | meaning
// IDLE   | waiting for seek_req; rejects out-of-range targets
// STEP   | compare pos with dest, take one step or start settling
// WAIT   | step interval running
// SETTLE | head settle time running, done pulses at its end
module ieeedrv_seek #(
  parameter int STEP_CE_4040 = 262144,
  parameter int STEP_CE_8250 = 131072,
  parameter int SETTLE_CE    = 16384
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce,
  ieeedrv_seek_if.slave bus
);

  localparam int MAX_STEP = (STEP_CE_4040 > STEP_CE_8250) ? STEP_CE_4040 : STEP_CE_8250;
  localparam int MAX_CE   = (MAX_STEP > SETTLE_CE) ? MAX_STEP : SETTLE_CE;
  localparam int CNT_W    = $clog2(MAX_CE + 1);

  // The STEP/IDLE cycle itself counts as one interval cycle, hence the -1.
  localparam logic [CNT_W-1:0] LD_4040   = CNT_W'(STEP_CE_4040 - 1);
  localparam logic [CNT_W-1:0] LD_8250   = CNT_W'(STEP_CE_8250 - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CE - 1);
  localparam logic [8:0]       DIR_4040  = 9'd34;
  localparam logic [8:0]       DIR_8250  = 9'd152;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, SETTLE} state_t;

  state_t           state, state_n;
  logic [8:0]       pos, pos_n, dest, dest_n;
  logic [1:0]       stp, stp_n;
  logic             hd, hd_n, typ, typ_n;
  logic             done_q, done_n, err_q, err_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [7:0] t_m1;
  logic [6:0] t_m78;
  logic       req_ok, req_side, tc;
  logic [8:0] req_dest;
  logic [7:0] cur;

  always_comb begin
    t_m1     = bus.target - 8'd1;
    t_m78    = 7'(bus.target - 8'd78);
    req_ok   = 1'b0;
    req_side = hd;
    req_dest = pos;
    if (bus.drv_type) begin
      req_ok   = (bus.target >= 8'd1) && (bus.target <= 8'd43);
      req_dest = {t_m1, 1'b0};
    end else if ((bus.target >= 8'd1) && (bus.target <= 8'd77)) begin
      req_ok   = 1'b1;
      req_side = 1'b0;
      req_dest = {t_m1[6:0], 2'b00};
    end else if ((bus.target >= 8'd78) && (bus.target <= 8'd154)) begin
      req_ok   = 1'b1;
      req_side = 1'b1;
      req_dest = {t_m78, 2'b00};
    end
  end

  assign tc = (cnt == '0) || (ce && (cnt == CNT_W'(1)));

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dest_n  = dest;
    stp_n   = stp;
    hd_n    = hd;
    typ_n   = typ;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (bus.home) begin
      state_n = IDLE;
      pos_n   = bus.drv_type ? DIR_4040 : DIR_8250;
      hd_n    = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.seek_req) begin
            if (req_ok) begin
              state_n = STEP;
              typ_n   = bus.drv_type;
              dest_n  = req_dest;
              if (!bus.drv_type) hd_n = req_side;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        STEP: begin
          // dest is always within 0..max, so moving toward it keeps pos in range
          if (pos < dest) begin
            pos_n   = pos + 9'd1;
            stp_n   = stp + 2'd1;
            cnt_n   = typ ? LD_4040 : LD_8250;
            state_n = WAIT;
          end else if (pos > dest) begin
            pos_n   = pos - 9'd1;
            stp_n   = stp - 2'd1;
            cnt_n   = typ ? LD_4040 : LD_8250;
            state_n = WAIT;
          end else begin
            cnt_n   = LD_SETTLE;
            state_n = SETTLE;
          end
        end
        WAIT: begin
          if (ce && (cnt != '0)) cnt_n = cnt - CNT_W'(1);
          if (tc) state_n = STEP;
        end
        SETTLE: begin
          if (ce && (cnt != '0)) cnt_n = cnt - CNT_W'(1);
          if (tc) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pos    <= bus.drv_type ? DIR_4040 : DIR_8250;
      dest   <= '0;
      stp    <= 2'd0;
      hd     <= 1'b0;
      typ    <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      dest   <= dest_n;
      stp    <= stp_n;
      hd     <= hd_n;
      typ    <= typ_n;
      cnt    <= cnt_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    if (bus.drv_type) cur = {1'b0, pos[7:1]} + 8'd1;
    else              cur = {1'b0, pos[8:2]} + (hd ? 8'd78 : 8'd1);
  end

  assign bus.stp       = stp;
  assign bus.hd        = hd;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.error     = err_q;
  assign bus.cur_track = cur;

endmodule

// File: tb/tb_ieeedrv_seek.sv
// Directed bench for ieeedrv_seek with short step/settle times; expected
// phase sequences and completion tracks are queued and matched on output.
module tb_ieeedrv_seek;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ce      = 1'b1;

  ieeedrv_seek_if bus();

  ieeedrv_seek #(.STEP_CE_4040(4), .STEP_CE_8250(4), .SETTLE_CE(2)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  localparam int EXP_GAP = 4;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int ncyc     = 0;
  int last_chg = 0;
  int seek_id  = 0;
  int last_id  = -1;
  bit mon_en   = 1'b0;
  logic [1:0] prev_stp = 2'd0;

  logic [1:0] exp_stp[$];
  logic [7:0] exp_trk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  task automatic mon();
    ncyc++;
    if (mon_en && (bus.stp !== prev_stp)) begin
      chk("stp_unexpected", exp_stp.size() != 0, 1);
      if (exp_stp.size() != 0) chk("stp_value", bus.stp, exp_stp.pop_front());
      if (last_id == seek_id) chk("stp_gap", ncyc - last_chg, EXP_GAP);
      last_id  = seek_id;
      last_chg = ncyc;
    end
    prev_stp = bus.stp;
    if (bus.done) begin
      done_cnt++;
      chk("done_unexpected", exp_trk.size() != 0, 1);
      if (exp_trk.size() != 0) chk("done_track", bus.cur_track, exp_trk.pop_front());
    end
    if (bus.error) err_cnt++;
  endtask

  task automatic clk1();
    @(negedge clk_sys);
    mon();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) clk1();
  endtask

  task automatic do_reset(input logic typ);
    mon_en       = 1'b0;
    bus.drv_type = typ;
    reset_n      = 1'b0;
    tick(2);
    reset_n = 1'b1;
    clk1();
    exp_stp.delete();
    seek_id++;
    mon_en = 1'b1;
  endtask

  task automatic req(input logic [7:0] t);
    seek_id++;
    bus.target   = t;
    bus.seek_req = 1'b1;
    clk1();
    bus.seek_req = 1'b0;
  endtask

  task automatic push_steps(input int n, input bit up, input logic [1:0] start);
    logic [1:0] s;
    s = start;
    for (int i = 0; i < n; i++) begin
      s = up ? s + 2'd1 : s - 2'd1;
      exp_stp.push_back(s);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      d0 = done_cnt;
      clk1();
      if (done_cnt != d0) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic home_pulse();
    bus.home = 1'b1;
    clk1();
    bus.home = 1'b0;
  endtask

  initial begin
    int d0, e0;
    logic [1:0] s0;
    bus.drv_type = 1'b1;
    bus.home     = 1'b0;
    bus.seek_req = 1'b0;
    bus.target   = 8'd0;

    // reset values, 4040
    tick(2);
    chk("rst_stp", bus.stp, 0);
    chk("rst_hd", bus.hd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_trk_4040", bus.cur_track, 18);
    do_reset(1'b1);

    // 4040 seek to 20: four upward steps
    push_steps(4, 1'b1, 2'd0);
    exp_trk.push_back(8'd20);
    req(8'd20);
    chk("t20_busy", bus.busy, 1);
    wait_done(100, "t20_done_timeout");
    chk("t20_busy_after", bus.busy, 0);
    chk("t20_done_once", done_cnt, 1);
    chk("t20_steps_left", exp_stp.size(), 0);
    chk("t20_trk", bus.cur_track, 20);

    // 8250 seek to 80: side 1, 144 downward steps
    do_reset(1'b0);
    chk("rst_trk_8250", bus.cur_track, 39);
    push_steps(144, 1'b0, 2'd0);
    exp_trk.push_back(8'd80);
    req(8'd80);
    chk("t80_hd", bus.hd, 1);
    chk("t80_busy", bus.busy, 1);
    wait_done(700, "t80_done_timeout");
    chk("t80_steps_left", exp_stp.size(), 0);
    chk("t80_trk", bus.cur_track, 80);
    chk("t80_busy_after", bus.busy, 0);

    // 4040 out-of-range targets, then the top valid track
    do_reset(1'b1);
    e0 = err_cnt;
    req(8'd0);
    chk("t0_error", bus.error, 1);
    chk("t0_busy", bus.busy, 0);
    clk1();
    chk("t0_error_pulse", bus.error, 0);
    req(8'd44);
    chk("t44_error", bus.error, 1);
    chk("t44_busy", bus.busy, 0);
    clk1();
    chk("err_count", err_cnt - e0, 2);
    chk("err_stp", bus.stp, 0);
    chk("err_trk", bus.cur_track, 18);
    push_steps(50, 1'b1, 2'd0);
    exp_trk.push_back(8'd43);
    req(8'd43);
    wait_done(300, "t43_done_timeout");
    chk("t43_steps_left", exp_stp.size(), 0);
    chk("t43_trk", bus.cur_track, 43);

    // 8250 seek to the current track: settle only, busy request ignored
    do_reset(1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    exp_trk.push_back(8'd39);
    req(8'd39);
    chk("t39_busy", bus.busy, 1);
    chk("t39_hd", bus.hd, 0);
    req(8'd100);
    wait_done(20, "t39_done_timeout");
    tick(3);
    chk("t39_done_once", done_cnt - d0, 1);
    chk("t39_no_error", err_cnt - e0, 0);
    chk("t39_busy_after", bus.busy, 0);
    chk("t39_hd_after", bus.hd, 0);
    chk("t39_stp", bus.stp, 0);

    // home mid-seek, 4040
    do_reset(1'b1);
    d0 = done_cnt;
    push_steps(24, 1'b1, 2'd0);
    req(8'd30);
    tick(10);
    s0 = bus.stp;
    home_pulse();
    exp_stp.delete();
    chk("home4_busy", bus.busy, 0);
    chk("home4_trk", bus.cur_track, 18);
    tick(20);
    chk("home4_stp_hold", bus.stp, s0);
    chk("home4_no_done", done_cnt - d0, 0);

    // home mid-seek, 8250
    do_reset(1'b0);
    push_steps(144, 1'b0, 2'd0);
    req(8'd80);
    tick(10);
    s0 = bus.stp;
    home_pulse();
    exp_stp.delete();
    chk("home8_busy", bus.busy, 0);
    chk("home8_trk", bus.cur_track, 39);
    tick(20);
    chk("home8_stp_hold", bus.stp, s0);
    chk("home8_no_done", done_cnt - d0, 0);

    // reset mid-seek, then a zero-step seek to the directory track
    do_reset(1'b1);
    push_steps(24, 1'b1, 2'd0);
    req(8'd30);
    tick(10);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("arst_stp", bus.stp, 0);
    chk("arst_busy", bus.busy, 0);
    tick(2);
    reset_n = 1'b1;
    clk1();
    exp_stp.delete();
    seek_id++;
    mon_en = 1'b1;
    chk("arst_no_done", done_cnt - d0, 0);
    exp_trk.push_back(8'd18);
    req(8'd18);
    wait_done(20, "t18_done_timeout");
    chk("t18_stp", bus.stp, 0);
    chk("t18_trk", bus.cur_track, 18);
    chk("trk_queue_empty", exp_trk.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
